fb_port_arbiter: RTL and testbench

- Sequences the single-port 640x480x8 frame-buffer BRAM between two requesters: the VGA scan-out reader and the sobel pixel-stream writer.
- VGA reads have strict priority. Sobel writes are buffered in a small FIFO and issued into idle BRAM cycles.
- The block generates the linear write address, detects frame completion and drives the BRAM port directly. It replaces the VGA block's hard-wired read-only BRAM hookup.

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_wr_fifo.sv | 69 ++++++
 rtl/fb_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_fb_port_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants and write-entry type for the frame-buffer port arbiter
package fb_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 19;
    localparam int FB_PIXELS   = H_ACTIVE * V_ACTIVE;
    localparam int WFIFO_DEPTH = 4;

    // One buffered sobel pixel; sof restarts the linear write address at 0.
    typedef struct packed {
        logic              sof;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous write FIFO with full/empty flags and same-cycle push/pop
module fb_wr_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rptr_q];

    // Storage array; no reset needed since empty_o masks stale entries.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy next state; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port frame-buffer BRAM arbiter: VGA reads first, buffered sobel writes fill idle cycles
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int H_ACTIVE    = fb_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = fb_pkg::V_ACTIVE,
    parameter int ADDR_W      = fb_pkg::ADDR_W,
    parameter int WFIFO_DEPTH = fb_pkg::WFIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              wr_valid_i,
    input  logic              wr_sof_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_din_o,
    output logic              bram_we_o,
    input  logic [DATA_W-1:0] bram_dout_i,
    output logic              frame_done_o,
    output logic [7:0]        frames_written_o
);

    localparam int                FB_PIX    = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIX - 1);

    wr_entry_t         push_entry;
    wr_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              rd_oor;
    logic [ADDR_W-1:0] wr_addr_sel;
    logic              wr_last;

    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_din_q, bram_din_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              done_pend_q, done_pend_d;
    logic              frame_done_q;
    logic [7:0]        frames_q;
    logic              rd_s1_q, rd_s1_oor_q;
    logic              rd_s2_q, rd_s2_oor_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    assign push_entry = '{sof: wr_sof_i, data: wr_data_i};

    fb_wr_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (wr_valid_i),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign wr_ready_o  = !fifo_full;
    assign pop         = !rd_req_i && !fifo_empty;
    // Widened compare so a frame that exactly fills the address space is still handled.
    assign rd_oor      = ({1'b0, rd_addr_i} >= (ADDR_W+1)'(FB_PIX));
    assign wr_addr_sel = head.sof ? '0 : wr_addr_q;
    assign wr_last     = (wr_addr_sel == LAST_ADDR);

    // Port arbitration: a read owns the cycle; a write only drains the FIFO when the reader is idle.
    always_comb begin
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        bram_we_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        done_pend_d = 1'b0;
        if (rd_req_i) begin
            if (!rd_oor) begin
                bram_addr_d = rd_addr_i;
            end
        end else if (pop) begin
            bram_addr_d = wr_addr_sel;
            bram_din_d  = head.data;
            bram_we_d   = 1'b1;
            wr_addr_d   = wr_last ? '0 : wr_addr_sel + ADDR_W'(1);
            done_pend_d = wr_last;
        end
    end

    // BRAM port, write address counter and frame-completion bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            bram_we_q    <= 1'b0;
            wr_addr_q    <= '0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frames_q     <= '0;
        end else begin
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
            bram_we_q    <= bram_we_d;
            wr_addr_q    <= wr_addr_d;
            done_pend_q  <= done_pend_d;
            frame_done_q <= done_pend_q;
            if (done_pend_q) begin
                frames_q <= frames_q + 8'd1;
            end
        end
    end

    // Read return pipeline: port drive, BRAM latency, then capture; out-of-range reads return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1_q     <= 1'b0;
            rd_s1_oor_q <= 1'b0;
            rd_s2_q     <= 1'b0;
            rd_s2_oor_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_s1_q     <= rd_req_i;
            rd_s1_oor_q <= rd_req_i && rd_oor;
            rd_s2_q     <= rd_s1_q;
            rd_s2_oor_q <= rd_s1_oor_q;
            rd_valid_q  <= rd_s2_q;
            if (rd_s2_q) begin
                rd_data_q <= rd_s2_oor_q ? '0 : bram_dout_i;
            end
        end
    end

    assign bram_addr_o      = bram_addr_q;
    assign bram_din_o       = bram_din_q;
    assign bram_we_o        = bram_we_q;
    assign frame_done_o     = frame_done_q;
    assign frames_written_o = frames_q;
    assign rd_valid_o       = rd_valid_q;
    assign rd_data_o        = rd_data_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - directed self-checking bench for fb_port_arbiter on a 16x4 frame
module tb_fb_port_arbiter;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          wr_valid;
    logic          wr_sof;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_din;
    logic          bram_we;
    logic [7:0]    bram_dout;
    logic          frame_done;
    logic [7:0]    frames_written;

    logic [7:0]    mem [0:127];

    int total = 0;
    int bad   = 0;
    int pushed;
    logic acc;

    always #5 clk = ~clk;

    fb_port_arbiter #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .ADDR_W      (AW),
        .WFIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rd_req_i         (rd_req),
        .rd_addr_i        (rd_addr),
        .rd_data_o        (rd_data),
        .rd_valid_o       (rd_valid),
        .wr_valid_i       (wr_valid),
        .wr_sof_i         (wr_sof),
        .wr_data_i        (wr_data),
        .wr_ready_o       (wr_ready),
        .bram_addr_o      (bram_addr),
        .bram_din_o       (bram_din),
        .bram_we_o        (bram_we),
        .bram_dout_i      (bram_dout),
        .frame_done_o     (frame_done),
        .frames_written_o (frames_written)
    );

    // Single-port BRAM model with 1-cycle read latency.
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr[6:0]] <= bram_din;
        bram_dout <= mem[bram_addr[6:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int j);
        return 8'((j * 7 + 3) & 255);
    endfunction

    initial begin
        rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_sof = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        chk("rst_bram_din", 32'(bram_din), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frames", 32'(frames_written), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;

        // 4-pixel burst with sof, reads idle
        for (int n = 0; n <= 4; n++) begin
            if (n < 4) begin
                wr_valid = 1'b1; wr_sof = (n == 0); wr_data = 8'(16 + n);
            end else begin
                wr_valid = 1'b0; wr_sof = 1'b0;
            end
            @(negedge clk);
            if (n == 0) begin
                chk("burst_no_bypass", 32'(bram_we), 32'd0);
            end else begin
                chk("burst_we", 32'(bram_we), 32'd1);
                chk("burst_addr", 32'(bram_addr), 32'(n - 1));
                chk("burst_din", 32'(bram_din), 32'(16 + n - 1));
            end
            chk("burst_frame_done", 32'(frame_done), 32'd0);
        end
        @(negedge clk);
        chk("burst_idle_we", 32'(bram_we), 32'd0);
        chk("burst_idle_addr", 32'(bram_addr), 32'd3);

        // preload addr 4 = 0x55, addr 5 = 0xA7
        wr_valid = 1'b1; wr_data = 8'h55;
        @(negedge clk);
        wr_data = 8'hA7;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        chk("preload_addr", 32'(bram_addr), 32'd5);
        chk("preload_din", 32'(bram_din), 32'hA7);
        @(negedge clk);
        chk("preload_idle", 32'(bram_we), 32'd0);

        // single read of addr 5
        rd_req = 1'b1; rd_addr = 19'd5;
        @(negedge clk);
        chk("rd_bram_addr", 32'(bram_addr), 32'd5);
        chk("rd_bram_we", 32'(bram_we), 32'd0);
        chk("rd_valid_e1", 32'(rd_valid), 32'd0);
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_valid_e2", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("rd_valid_e3", 32'(rd_valid), 32'd1);
        chk("rd_data_e3", 32'(rd_data), 32'hA7);
        @(negedge clk);
        chk("rd_valid_e4", 32'(rd_valid), 32'd0);

        // reads held for 10 cycles while 6 pixels are offered
        rd_req = 1'b1; rd_addr = 19'd1;
        wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 8'h20; pushed = 0;
        for (int c = 0; c < 10; c++) begin
            acc = wr_valid && wr_ready;
            @(negedge clk);
            if (acc) pushed++;
            chk("hold_no_we", 32'(bram_we), 32'd0);
            chk("hold_wr_ready", 32'(wr_ready), (c < 3) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                chk("hold_rd_valid", 32'(rd_valid), 32'd1);
                chk("hold_rd_data", 32'(rd_data), 32'h11);
            end
            if (pushed < 6) wr_data = 8'(32 + pushed);
            else wr_valid = 1'b0;
        end
        rd_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            acc = wr_valid && wr_ready;
            @(negedge clk);
            if (acc) pushed++;
            chk("drain_we", 32'(bram_we), 32'd1);
            chk("drain_addr", 32'(bram_addr), 32'(6 + i));
            chk("drain_din", 32'(bram_din), 32'(32 + i));
            if (pushed < 6) wr_data = 8'(32 + pushed);
            else wr_valid = 1'b0;
        end
        @(negedge clk);
        chk("drain_done_we", 32'(bram_we), 32'd0);

        // out-of-range read
        rd_req = 1'b1; rd_addr = 19'(H * V);
        @(negedge clk);
        chk("oor_we", 32'(bram_we), 32'd0);
        chk("oor_addr_hold", 32'(bram_addr), 32'd11);
        rd_req = 1'b0; rd_addr = '0;
        @(negedge clk);
        chk("oor_valid_e2", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("oor_valid_e3", 32'(rd_valid), 32'd1);
        chk("oor_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        chk("oor_valid_e4", 32'(rd_valid), 32'd0);

        // full frame from sof (aborts the partial frame at counter 12)
        for (int n = 1; n <= 68; n++) begin
            if (n - 1 < H * V) begin
                wr_valid = 1'b1; wr_sof = (n == 1); wr_data = pat(n - 1);
            end else begin
                wr_valid = 1'b0; wr_sof = 1'b0;
            end
            @(negedge clk);
            if (n >= 2 && n <= 65) begin
                chk("frame_we", 32'(bram_we), 32'd1);
                chk("frame_addr", 32'(bram_addr), 32'(n - 2));
                chk("frame_din", 32'(bram_din), 32'(pat(n - 2)));
            end
            chk("frame_done", 32'(frame_done), (n == 66) ? 32'd1 : 32'd0);
            chk("frames_written", 32'(frames_written), (n >= 66) ? 32'd1 : 32'd0);
        end
        wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 8'h99;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wrap_we", 32'(bram_we), 32'd1);
        chk("wrap_addr", 32'(bram_addr), 32'd0);
        chk("wrap_din", 32'(bram_din), 32'h99);
        chk("wrap_frames", 32'(frames_written), 32'd1);

        // reset with reads in flight and 3 FIFO entries
        rd_req = 1'b1; rd_addr = 19'd2; wr_valid = 1'b1; wr_data = 8'h71;
        @(negedge clk);
        wr_data = 8'h72;
        @(negedge clk);
        wr_data = 8'h73;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        chk("arst_bram_we", 32'(bram_we), 32'd0);
        chk("arst_bram_addr", 32'(bram_addr), 32'd0);
        chk("arst_bram_din", 32'(bram_din), 32'd0);
        chk("arst_frame_done", 32'(frame_done), 32'd0);
        chk("arst_frames", 32'(frames_written), 32'd0);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        rd_req = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("post_rst_we", 32'(bram_we), 32'd0);
        end
        wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 8'h88;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_we", 32'(bram_we), 32'd1);
        chk("post_rst_wr_addr", 32'(bram_addr), 32'd0);
        chk("post_rst_wr_din", 32'(bram_din), 32'h88);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
